// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-port register file with a pending
// scoreboard and a sequential clear engine.
//
// Ports:
//   clk_i, reset_i       clock (rising edge), async active-high reset
//   stall_i              blocks write and busy-set acceptance
//   wr_en_i/addr/data    NUM_WR write ports, higher index has priority
//   rd_addr_i            NUM_RD combinational read addresses
//   rd_data_o/rd_pend_o  read data and pending bit per read port
//   busy_set_i/addr_i    mark an entry pending (long-latency producer)
//   clear_i              start the sequential clear
//   ready_o              1 = idle, 0 = clear in progress
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | normal operation, writes/busy sets accepted, bypass active
// S_CLEAR | zeroing entry r_cnt each cycle, external requests dropped
module reg_file_mp #(
  parameter  int XLEN     = 32,
  parameter  int DEPTH    = 32,
  parameter  int NUM_RD   = 3,
  parameter  int NUM_WR   = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   stall_i,
  input  logic [NUM_WR-1:0]      wr_en_i,
  input  logic [NUM_WR*AW-1:0]   wr_addr_i,
  input  logic [NUM_WR*XLEN-1:0] wr_data_i,
  input  logic [NUM_RD*AW-1:0]   rd_addr_i,
  output logic [NUM_RD*XLEN-1:0] rd_data_o,
  output logic [NUM_RD-1:0]      rd_pend_o,
  input  logic                   busy_set_i,
  input  logic [AW-1:0]          busy_addr_i,
  input  logic                   clear_i,
  output logic                   ready_o
);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t            r_state;
  logic [AW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pend;

  logic              w_idle;
  logic              w_open;
  logic [NUM_WR-1:0] w_wr_acc;
  logic [AW-1:0]     w_wr_addr [NUM_WR];
  logic [XLEN-1:0]   w_wr_data [NUM_WR];
  logic              w_busy_acc;

  assign w_idle  = (r_state == S_IDLE);
  assign ready_o = w_idle;
  // Nothing is accepted (nor bypassed) while reset is held, so reads stay 0.
  assign w_open  = w_idle & ~stall_i & ~reset_i;

  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
    assign w_wr_addr[k] = wr_addr_i[k*AW +: AW];
    assign w_wr_data[k] = wr_data_i[k*XLEN +: XLEN];
    assign w_wr_acc[k]  = wr_en_i[k] & w_open &
                          !((ZERO_REG != 0) && (w_wr_addr[k] == '0));
  end

  assign w_busy_acc = busy_set_i & w_open &
                      !((ZERO_REG != 0) && (busy_addr_i == '0));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (r_state == S_IDLE) begin
      // Ascending loop: the last (highest-index) non-blocking write wins.
      for (int k = 0; k < NUM_WR; k++) begin
        if (w_wr_acc[k]) begin
          r_mem[w_wr_addr[k]]  <= w_wr_data[k];
          r_pend[w_wr_addr[k]] <= 1'b0;
        end
      end
      // After the write clears so a new producer's set takes priority.
      if (w_busy_acc) r_pend[busy_addr_i] <= 1'b1;
      if (clear_i) begin
        r_state <= S_CLEAR;
        r_cnt   <= '0;
      end
    end else begin
      r_mem[r_cnt]  <= '0;
      r_pend[r_cnt] <= 1'b0;
      if (r_cnt == AW'(DEPTH-1)) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + AW'(1);
      end
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_pend;
    logic            w_hit;

    assign w_addr = rd_addr_i[r*AW +: AW];

    always_comb begin
      w_data = r_mem[w_addr];
      w_pend = r_pend[w_addr];
      w_hit  = 1'b0;
      if (BYPASS != 0) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (w_wr_acc[k] && (w_wr_addr[k] == w_addr)) begin
            w_data = w_wr_data[k];
            w_hit  = 1'b1;
          end
        end
        if (w_hit && !(w_busy_acc && (busy_addr_i == w_addr))) w_pend = 1'b0;
      end
      if ((ZERO_REG != 0) && (w_addr == '0)) begin
        w_data = '0;
        w_pend = 1'b0;
      end
    end

    assign rd_data_o[r*XLEN +: XLEN] = w_data;
    assign rd_pend_o[r]              = w_pend;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;
  localparam int XLEN   = 32;
  localparam int DEPTH  = 32;
  localparam int AW     = 5;
  localparam int NUM_RD = 3;
  localparam int NUM_WR = 2;

  logic                   clk_i = 1'b0;
  logic                   reset_i;
  logic                   stall_i;
  logic [NUM_WR-1:0]      wr_en_i;
  logic [NUM_WR*AW-1:0]   wr_addr_i;
  logic [NUM_WR*XLEN-1:0] wr_data_i;
  logic [NUM_RD*AW-1:0]   rd_addr_i;
  logic                   busy_set_i;
  logic [AW-1:0]          busy_addr_i;
  logic                   clear_i;
  // instance a: integer file (ZERO_REG=1, BYPASS=1); b: float file, no bypass
  logic [NUM_RD*XLEN-1:0] rd_data_a, rd_data_b;
  logic [NUM_RD-1:0]      rd_pend_a, rd_pend_b;
  logic                   ready_a, ready_b;

  always #5 clk_i = ~clk_i;

  reg_file_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
                .ZERO_REG(1), .BYPASS(1)) u_dut_a (
    .clk_i(clk_i), .reset_i(reset_i), .stall_i(stall_i), .wr_en_i(wr_en_i),
    .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data_a), .rd_pend_o(rd_pend_a), .busy_set_i(busy_set_i),
    .busy_addr_i(busy_addr_i), .clear_i(clear_i), .ready_o(ready_a));

  reg_file_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
                .ZERO_REG(0), .BYPASS(0)) u_dut_b (
    .clk_i(clk_i), .reset_i(reset_i), .stall_i(stall_i), .wr_en_i(wr_en_i),
    .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data_b), .rd_pend_o(rd_pend_b), .busy_set_i(busy_set_i),
    .busy_addr_i(busy_addr_i), .clear_i(clear_i), .ready_o(ready_b));

  // ---------------- reference model ----------------
  logic [XLEN-1:0] m_mem  [2][DEPTH];
  logic            m_pend [2][DEPTH];
  bit              m_clr;
  int              m_pos;

  typedef struct {
    logic [1:0][NUM_RD*XLEN-1:0] data;
    logic [1:0][NUM_RD-1:0]      pend;
    logic [1:0]                  rdy;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic bit has_zero(int i); return (i == 0); endfunction
  function automatic bit has_byp(int i);  return (i == 0); endfunction

  function automatic logic [AW-1:0] waddr(int k); return wr_addr_i[k*AW +: AW]; endfunction
  function automatic logic [XLEN-1:0] wdata(int k); return wr_data_i[k*XLEN +: XLEN]; endfunction

  function automatic bit open_now();
    return !stall_i && !m_clr && !reset_i;
  endfunction

  function automatic bit acc(int i, int k);
    return wr_en_i[k] && open_now() && !(has_zero(i) && waddr(k) == 0);
  endfunction

  function automatic bit busy_ok(int i);
    return busy_set_i && open_now() && !(has_zero(i) && busy_addr_i == 0);
  endfunction

  // highest-index accepted port writing address a, or -1
  function automatic int last_writer(int i, logic [AW-1:0] a);
    for (int k = NUM_WR-1; k >= 0; k--)
      if (acc(i, k) && waddr(k) == a) return k;
    return -1;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      e.rdy[i] = !m_clr;
      for (int r = 0; r < NUM_RD; r++) begin
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            p;
        int              w;
        a = rd_addr_i[r*AW +: AW];
        d = m_mem[i][a];
        p = m_pend[i][a];
        w = last_writer(i, a);
        if (has_byp(i) && w >= 0) begin
          d = wdata(w);
          if (!(busy_ok(i) && busy_addr_i == a)) p = 1'b0;
        end
        if (has_zero(i) && a == 0) begin
          d = '0;
          p = 1'b0;
        end
        e.data[i][r*XLEN +: XLEN] = d;
        e.pend[i][r] = p;
      end
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < DEPTH; j++) begin
        m_mem[i][j]  = '0;
        m_pend[i][j] = 1'b0;
      end
    m_clr = 0;
    m_pos = 0;
  endtask

  task automatic model_edge();
    if (reset_i) begin
      model_reset();
      return;
    end
    if (!m_clr) begin
      for (int i = 0; i < 2; i++) begin
        int w;
        for (int a = 0; a < DEPTH; a++) begin
          w = last_writer(i, AW'(a));
          if (w >= 0) begin
            m_mem[i][a]  = wdata(w);
            m_pend[i][a] = 1'b0;
          end
        end
        if (busy_ok(i)) m_pend[i][busy_addr_i] = 1'b1;
      end
      if (clear_i) begin
        m_clr = 1;
        m_pos = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_mem[i][m_pos]  = '0;
        m_pend[i][m_pos] = 1'b0;
      end
      m_pos++;
      if (m_pos == DEPTH) m_clr = 0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle_in();
    stall_i = 0; wr_en_i = '0; wr_addr_i = '0; wr_data_i = '0;
    rd_addr_i = '0; busy_set_i = 0; busy_addr_i = '0; clear_i = 0;
  endtask

  task automatic set_wr(int k, logic [AW-1:0] a, logic [XLEN-1:0] d);
    wr_en_i[k] = 1'b1;
    wr_addr_i[k*AW +: AW] = a;
    wr_data_i[k*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd_all(logic [AW-1:0] a);
    for (int r = 0; r < NUM_RD; r++) rd_addr_i[r*AW +: AW] = a;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 2) == 0) return AW'($urandom_range(0, 3));
    return AW'($urandom_range(0, DEPTH-1));
  endfunction

  task automatic rand_rd();
    for (int r = 0; r < NUM_RD; r++) rd_addr_i[r*AW +: AW] = rand_addr();
  endtask

  // inputs are already driven; push the expectation and advance one cycle
  task automatic apply();
    if (reset_i) model_reset();
    sb.push_back(predict());
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  // ---------------- monitor ----------------
  task automatic check(string name, logic [NUM_RD*XLEN-1:0] act, logic [NUM_RD*XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("rd_data_a", rd_data_a, e.data[0]);
      check("rd_pend_a", 96'(rd_pend_a), 96'(e.pend[0]));
      check("ready_a",   96'(ready_a),   96'(e.rdy[0]));
      check("rd_data_b", rd_data_b, e.data[1]);
      check("rd_pend_b", 96'(rd_pend_b), 96'(e.pend[1]));
      check("ready_b",   96'(ready_b),   96'(e.rdy[1]));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    idle_in();
    reset_i = 1'b1;
    model_reset();
    @(posedge clk_i); #1;
    rand_rd(); apply();
    rand_rd(); apply();
    reset_i = 1'b0;

    // single write then read on all ports
    idle_in(); set_wr(0, 5, 32'hDEADBEEF); set_rd_all(5); apply();
    idle_in(); set_rd_all(5); apply();

    // same-address write on both ports, same-cycle read
    idle_in(); set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22); set_rd_all(7); apply();
    idle_in(); set_rd_all(7); apply();

    // entry 0 write and busy set
    idle_in(); set_wr(0, 0, 32'hFFFF_FFFF); busy_set_i = 1; busy_addr_i = 0; set_rd_all(0); apply();
    idle_in(); set_rd_all(0); apply();

    // scoreboard on entry 9
    idle_in(); busy_set_i = 1; busy_addr_i = 9; set_rd_all(9); apply();
    idle_in(); set_rd_all(9); apply();
    idle_in(); set_wr(0, 9, 32'h55); set_rd_all(9); apply();
    idle_in(); set_rd_all(9); apply();
    idle_in(); busy_set_i = 1; busy_addr_i = 9; set_wr(1, 9, 32'h66); set_rd_all(9); apply();
    idle_in(); set_rd_all(9); apply();

    // fill, clear with dropped writes, then read back everything
    for (int a = 1; a < DEPTH; a++) begin
      idle_in(); set_wr(1, AW'(a), $urandom); rand_rd(); apply();
    end
    idle_in(); clear_i = 1; set_wr(0, 3, 32'hA5A5); set_rd_all(3); apply();
    for (int c = 0; c < DEPTH + 2; c++) begin
      idle_in(); set_wr(0, rand_addr(), $urandom); set_wr(1, rand_addr(), $urandom);
      busy_set_i = 1; busy_addr_i = rand_addr(); clear_i = (c == 4); rand_rd(); apply();
    end
    for (int a = 0; a < DEPTH; a += NUM_RD) begin
      idle_in();
      for (int r = 0; r < NUM_RD; r++) rd_addr_i[r*AW +: AW] = AW'((a + r) % DEPTH);
      apply();
    end

    // reset in the middle of a clear, with a write presented
    for (int a = 1; a < 8; a++) begin
      idle_in(); set_wr(0, AW'(a), $urandom); busy_set_i = 1; busy_addr_i = AW'(a + 8); apply();
    end
    idle_in(); clear_i = 1; apply();
    for (int c = 0; c < 10; c++) begin idle_in(); rand_rd(); apply(); end
    idle_in(); reset_i = 1; set_wr(0, 4, 32'h1234); rand_rd(); apply();
    reset_i = 0;
    idle_in(); set_rd_all(4); apply();

    // stall blocks a write to entry 3
    idle_in(); set_wr(0, 3, 32'h77); apply();
    idle_in(); stall_i = 1; set_wr(0, 3, 32'h99); busy_set_i = 1; busy_addr_i = 3; set_rd_all(3); apply();
    idle_in(); set_rd_all(3); apply();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      idle_in();
      reset_i = ($urandom_range(0, 399) == 0);
      stall_i = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < NUM_WR; k++)
        if ($urandom_range(0, 1) == 1) set_wr(k, rand_addr(), $urandom);
      busy_set_i  = ($urandom_range(0, 2) == 0);
      busy_addr_i = rand_addr();
      clear_i     = ($urandom_range(0, 99) == 0);
      rand_rd();
      apply();
    end
    reset_i = 0;
    idle_in();
    @(negedge clk_i);
    @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file, the next generation of the core integer/float register files. Configurable depth, width, read-port and write-port counts. Optional hard-wired zero entry and write-to-read bypass. Adds a per-entry pending scoreboard for long-latency producers and a sequential clear engine, so software or the pipeline can zero the file without asserting reset.

Parameters:
XLEN, 32, data width in bits
DEPTH, 32, number of entries; power of two, at least 2; AW = $clog2(DEPTH)
NUM_RD, 3, number of combinational read ports
NUM_WR, 2, number of write ports; higher index has priority
ZERO_REG, 1, 1: entry 0 reads 0, ignores writes, never pending (integer file); 0: entry 0 is ordinary (float file)
BYPASS, 1, 1: a write accepted this cycle is visible on same-cycle reads

Ports:
clk_i  in  1  clock, rising edge
reset_i  in  1  asynchronous, active-high reset
stall_i  in  1  blocks write and busy-set acceptance; clear engine ignores it
wr_en_i  in  NUM_WR  write enable per port
wr_addr_i  in  NUM_WR*AW  write addresses, port k in slice [k*AW +: AW]
wr_data_i  in  NUM_WR*XLEN  write data, port k in slice [k*XLEN +: XLEN]
rd_addr_i  in  NUM_RD*AW  read addresses
rd_data_o  out  NUM_RD*XLEN  read data
rd_pend_o  out  NUM_RD  pending bit of each read address
busy_set_i  in  1  mark busy_addr_i pending (long-latency op issued)
busy_addr_i  in  AW  entry to mark pending
clear_i  in  1  start the sequential clear
ready_o  out  1  1 = idle; 0 = clear in progress

Behaviour:
- Reset (asynchronous): all entries 0, all pending bits 0, FSM in IDLE, counter 0, ready_o=1. Outputs are therefore 0 on every rd_data_o and rd_pend_o slice.
- Write acceptance: port k is accepted when wr_en_i[k] & !stall_i & state==IDLE & !(ZERO_REG & addr==0). Storage updates on the next clock edge.
- Multiple accepted ports with the same address: the highest index wins. Ports with different addresses all write.
- Reads are combinational, zero latency.
  - ZERO_REG & addr==0: data 0, pend 0.
  - Otherwise, if BYPASS and state==IDLE and an accepted write targets the address: data = that write's data (highest-index port).
  - Else data = stored value.
- Scoreboard (one pending bit per entry):
  - Accepted busy_set_i sets pend[busy_addr_i]; it is ignored for entry 0 when ZERO_REG.
  - Any accepted write clears pend[addr].
  - Set and clear on the same entry in the same cycle: set wins, because it marks a new producer.
  - rd_pend_o = registered pend bit. With BYPASS=1, a same-cycle accepted write to that address forces it to 0 unless a same-cycle busy set targets the same address.
- Clear FSM, states IDLE and CLEAR:
  - IDLE: ready_o=1. clear_i=1 moves to CLEAR with cnt=0.
  - CLEAR: ready_o=0. Each cycle, entry cnt is written 0 and pend[cnt] cleared, then cnt increments. When cnt==DEPTH-1 is cleared, the FSM returns to IDLE next cycle, so the clear takes exactly DEPTH cycles.
  - In CLEAR, external writes and busy sets are dropped (not queued), bypass is disabled, and clear_i is ignored. stall_i does not pause the sequence.
  - A write in the same cycle as clear_i in IDLE is still accepted; that entry is later overwritten by the clear.
- Reset asserted mid-clear aborts the sequence immediately: all entries 0, IDLE, ready_o=1.
- cnt is AW bits wide and must not wrap past DEPTH-1.

Test Plan:
- Reset, then write 0xDEADBEEF to entry 5 via port 0; next cycle read entry 5 on all ports -> 0xDEADBEEF, rd_pend_o=0.
- Same cycle: port 0 writes 0x11 and port 1 writes 0x22 to entry 7, BYPASS=1 -> same-cycle read of entry 7 = 0x22; stored value = 0x22.
- ZERO_REG=1: write 0xFFFF_FFFF to entry 0 and busy_set entry 0 -> read entry 0 = 0, pend=0. ZERO_REG=0 build: read entry 0 = 0xFFFF_FFFF.
- busy_set entry 9 -> rd_pend_o=1 from the next cycle. Write entry 9 with 0x55 -> pend drops next cycle (same cycle under BYPASS). Set and write entry 9 together -> pend remains 1.
- Fill entries 1..31, pulse clear_i -> ready_o=0 for exactly 32 cycles. Writes during that window are dropped. Afterwards all reads return 0 with all pend bits 0.
- Assert reset_i at clear cycle 10 with a write issued from stall_i=0 -> ready_o=1 at once and all entries 0. stall_i=1 with a write to entry 3 -> entry 3 is unchanged.
